// File: rtl/nios_system_char_transmitter.sv
// rtl/nios_system_char_transmitter.sv - Avalon-MM serial character transmitter (8N1)
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   address    register select (0 data, 1 status, 2/3 reserved)
//   chipselect slave select; writes ignored when low
//   write_n    active-low write strobe
//   writedata  write data (only [7:0] carries a character)
//   readdata   registered read data, latency 1
//   tx_out     serial line, idles high
//   char_sent  one-cycle pulse during the last cycle of the stop bit

module nios_system_char_transmitter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx_out,
    output logic        char_sent
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    // char_sent is registered, so it is scheduled one cycle before the stop bit ends
    localparam logic [15:0] PULSE_CNT = 16'(CLKS_PER_BIT - 2);

    state_t      state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic [7:0]  last_char;
    logic        sent;
    logic        overrun;

    logic        wr_en;
    logic        wr_data;
    logic        wr_clear;
    logic        bit_done;
    logic        busy;
    logic [31:0] rd_mux;
    logic        unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign wr_data          = wr_en && (address == 2'd0);
    assign wr_clear         = wr_en && (address == 2'd1);
    assign bit_done         = (clk_cnt == LAST_CNT);
    assign busy             = (state != IDLE);
    assign unused_writedata = ^writedata[31:8];

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            2'd0:    rd_mux = {24'd0, last_char};
            2'd1:    rd_mux = {29'd0, overrun, sent, busy};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            clk_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            last_char <= 8'd0;
            sent      <= 1'b0;
            overrun   <= 1'b0;
            readdata  <= 32'd0;
            tx_out    <= 1'b1;
            char_sent <= 1'b0;
        end else begin
            readdata  <= rd_mux;
            char_sent <= (state == STOP) && (clk_cnt == PULSE_CNT);

            if (wr_data && busy) begin
                overrun <= 1'b1;
            end
            if (wr_clear) begin
                sent    <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    tx_out  <= 1'b1;
                    clk_cnt <= 16'd0;
                    if (wr_data) begin
                        last_char <= writedata[7:0];
                        shift_reg <= writedata[7:0];
                        tx_out    <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        clk_cnt <= 16'd0;
                        bit_idx <= 3'd0;
                        tx_out  <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        clk_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            tx_out <= 1'b1;
                            state  <= STOP;
                        end else begin
                            // next bit is presented straight from shift_reg[1]
                            // so tx_out stays flop-driven without an extra cycle
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx_out    <= shift_reg[1];
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        clk_cnt <= 16'd0;
                        // placed after the clear-write so completion wins a collision
                        sent    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_char_transmitter.sv
// tb/tb_nios_system_char_transmitter.sv - self-checking bench for nios_system_char_transmitter

module tb_nios_system_char_transmitter;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        tx_out;
    logic        char_sent;

    int checks = 0;
    int fails  = 0;

    nios_system_char_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .tx_out     (tx_out),
        .char_sent  (char_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is described only by the edge it was accepted on and its byte.
    int         cyc = 0;
    int         m_start = -1000;
    logic [7:0] m_byte = 8'd0;
    logic [7:0] m_last = 8'd0;
    logic       m_sent = 1'b0;
    logic       m_ovr = 1'b0;
    logic [31:0] exp_rd = 32'd0;

    always @(posedge clk) begin
        logic act;
        logic wr;
        cyc++;
        if (!reset_n) begin
            m_start = -1000;
            m_last  = 8'd0;
            m_sent  = 1'b0;
            m_ovr   = 1'b0;
            exp_rd  = 32'd0;
        end else begin
            act = ((cyc - 1 - m_start) >= 0) && ((cyc - 1 - m_start) < FRAME);
            case (address)
                2'd0:    exp_rd = {24'd0, m_last};
                2'd1:    exp_rd = {29'd0, m_ovr, m_sent, act};
                default: exp_rd = 32'd0;
            endcase
            wr = chipselect && !write_n;
            if (wr && address == 2'd0) begin
                if (act) m_ovr = 1'b1;
                else begin
                    m_start = cyc;
                    m_byte  = writedata[7:0];
                    m_last  = writedata[7:0];
                end
            end
            if (wr && address == 2'd1) begin
                m_sent = 1'b0;
                m_ovr  = 1'b0;
            end
            if (cyc - m_start == FRAME) m_sent = 1'b1;
        end
    end

    always @(negedge clk) begin
        int   o;
        int   g;
        logic e_tx;
        o    = cyc - m_start;
        e_tx = 1'b1;
        if (o >= 0 && o < FRAME) begin
            g = o / CPB;
            if (g == 0)      e_tx = 1'b0;
            else if (g == 9) e_tx = 1'b1;
            else             e_tx = m_byte[g-1];
        end
        check("model_tx_out", {31'd0, tx_out}, {31'd0, e_tx});
        check("model_char_sent", {31'd0, char_sent}, {31'd0, (o == FRAME - 1)});
        check("model_readdata", readdata, exp_rd);
    end

    // Entered and left at a falling edge; the write is sampled by the rising edge in between.
    task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic capture(output logic [39:0] wave, output logic [39:0] pulses);
        for (int i = 0; i < FRAME; i++) begin
            wave[i]   = tx_out;
            pulses[i] = char_sent;
            @(negedge clk);
        end
    endtask

    task automatic wait_pulse(input string name);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            if (char_sent) found = 1'b1;
            else @(negedge clk);
        end
        check(name, {31'd0, found}, 32'd1);
    endtask

    function automatic logic [7:0] data_bits(input logic [39:0] wave);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = wave[CPB * (k + 1) + 2];
        return b;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [39:0] wave;
        logic [39:0] pulses;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("reset_tx_out", {31'd0, tx_out}, 32'd1);
        check("reset_char_sent", {31'd0, char_sent}, 32'd0);
        check("reset_readdata", readdata, 32'd0);
        do_read(2'd1, d);
        check("reset_status", d, 32'h0);

        // unused addresses and deselected writes
        do_read(2'd2, d);
        check("read_addr2", d, 32'h0);
        do_read(2'd3, d);
        check("read_addr3", d, 32'h0);
        do_write(2'd2, 32'hFF, 1'b1);
        do_write(2'd3, 32'hFF, 1'b1);
        do_write(2'd0, 32'hFF, 1'b0);
        repeat (6) @(negedge clk);
        check("no_frame_tx", {31'd0, tx_out}, 32'd1);
        do_read(2'd1, d);
        check("no_frame_status", d, 32'h0);

        // single frame 0x55
        do_write(2'd0, 32'h55, 1'b1);
        address = 2'd1;
        for (int i = 0; i < FRAME; i++) begin
            wave[i]   = tx_out;
            pulses[i] = char_sent;
            if (i == 20) check("busy_status", readdata, 32'h1);
            @(negedge clk);
        end
        check("wave_0x55", wave, 40'hF0F0F0F0F0);
        check("pulse_0x55", pulses, 40'h8000000000);
        do_read(2'd1, d);
        check("sent_status", d, 32'h2);
        do_write(2'd1, 32'h0, 1'b1);

        // LSB ordering and readback
        do_write(2'd0, 32'hA3, 1'b1);
        capture(wave, pulses);
        check("bits_0xA3", {24'd0, data_bits(wave)}, 32'hA3);
        do_read(2'd0, d);
        check("readback_0xA3", d, 32'hA3);
        do_write(2'd1, 32'h0, 1'b1);

        // overrun at cycle 10
        do_write(2'd0, 32'h11, 1'b1);
        repeat (9) @(negedge clk);
        do_write(2'd0, 32'h22, 1'b1);
        repeat (30) @(negedge clk);
        do_read(2'd1, d);
        check("overrun_status", d, 32'h6);
        do_read(2'd0, d);
        check("overrun_last_char", d, 32'h11);
        do_write(2'd1, 32'h0, 1'b1);

        // clear collides with completion, then a clear one cycle later
        do_write(2'd0, 32'h5A, 1'b1);
        wait_pulse("collision_pulse_seen");
        do_write(2'd1, 32'h0, 1'b1);
        do_write(2'd1, 32'h0, 1'b1);
        check("collision_status", readdata, 32'h2);
        do_read(2'd1, d);
        check("cleared_status", d, 32'h0);

        // data write in the final stop cycle is an overrun; next idle write starts a frame
        do_write(2'd0, 32'h81, 1'b1);
        wait_pulse("stop_pulse_seen");
        do_write(2'd0, 32'h99, 1'b1);
        do_read(2'd1, d);
        check("late_write_status", d, 32'h6);
        do_read(2'd0, d);
        check("late_write_last_char", d, 32'h81);
        do_write(2'd0, 32'h42, 1'b1);
        capture(wave, pulses);
        check("bits_0x42", {24'd0, data_bits(wave)}, 32'h42);
        do_write(2'd1, 32'h0, 1'b1);

        // reset mid-frame
        do_write(2'd0, 32'h00, 1'b1);
        repeat (15) @(negedge clk);
        check("midframe_low", {31'd0, tx_out}, 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("reset_async_tx", {31'd0, tx_out}, 32'd1);
        check("reset_async_rd", readdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        do_read(2'd1, d);
        check("post_reset_status", d, 32'h0);
        do_write(2'd0, 32'h3C, 1'b1);
        capture(wave, pulses);
        check("bits_0x3C", {24'd0, data_bits(wave)}, 32'h3C);
        check("pulse_0x3C", pulses, 40'h8000000000);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/nios_system_char_transmitter.md
# nios_system_char_transmitter

The transmit-side serial character port for the Nios II system. It is an Avalon-MM slave: the CPU writes a byte, and the block shifts it out on `tx_out` as an 8N1 asynchronous serial frame. Completion is reported through a sticky status bit and a one-cycle `char_sent` pulse. It is the counterpart of the system's character-received input port and uses the same read-latency-1 register interface.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535; counter width 16 bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset; asynchronous, active-low.
- address  input  2  register select.
- chipselect  input  1  slave select; writes are ignored when low.
- write_n  input  1  active-low write strobe; a write is `chipselect & ~write_n`.
- writedata  input  32  write data.
- readdata  output  32  registered read data, latency 1.
- tx_out  output  1  serial line; idles high.
- char_sent  output  1  one-cycle pulse at end of stop bit.

## Operation
Register map, read values:
- addr 0: {24'b0, last_char[7:0]}.
- addr 1: {29'b0, overrun, sent, busy}.
- addr 2, 3: read 0.

Write actions:
- Write addr 0 while idle: latch `writedata[7:0]` into last_char and the shift register; start a frame.
- Write addr 0 while busy: data discarded, last_char unchanged, overrun := 1.
- Write addr 1, any data: clears sent and overrun.
- Writes to addr 2 and 3 have no effect.

State machine (states IDLE, START, DATA, STOP):
- IDLE: tx_out = 1, busy = 0. An accepted addr-0 write moves to START.
- START: tx_out = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx_out = shift[0] for CLKS_PER_BIT cycles. Then shift right and increment the index. After index 7 completes, go to STOP. Bits go out LSB first.
- STOP: tx_out = 1 for CLKS_PER_BIT cycles, then IDLE. On the final STOP cycle, set sent := 1 and pulse char_sent.
- busy = (state != IDLE).

Simultaneous events and boundary conditions:
- Frame completion and an addr-1 clear-write in the same cycle: set wins, so sent = 1 afterward.
- An overrun write in the same cycle as a clear-write cannot occur, because there is one write port.
- An addr-0 write in the final STOP cycle is still a busy write and counts as an overrun. The earliest accepted new write is the first IDLE cycle, so there is no back-to-back frame without one idle cycle.
- The bit counter reloads at each state change; there is no cumulative drift.

## Timing
- Reset values:
  - readdata = 0, tx_out = 1, char_sent = 0.
  - state = IDLE, last_char = 0, sent = 0, overrun = 0.
- Reset asserted mid-frame: immediate return to the reset values; the partial frame is abandoned and tx_out goes high asynchronously.
- readdata is registered every cycle from the address mux, independent of chipselect. Data is valid on the edge after address is presented (read latency 1).
- Write accepted at edge T:
  - tx_out is low starting at edge T+1.
  - busy reads 1 for an address presented at T+1.
  - The frame occupies exactly 10*CLKS_PER_BIT cycles, edges T+1 .. T+10*CLKS_PER_BIT.
  - char_sent is high during the last cycle of the frame.
  - IDLE is entered at edge T+1+10*CLKS_PER_BIT.
- tx_out and char_sent are driven directly from flops, so there are no glitches.

## Test plan
All cases use CLKS_PER_BIT=4.
- Reset mid-frame: assert reset_n low during DATA -> tx_out = 1 immediately; status reads 0x0; a new write of 0x3C afterward produces a correct full frame.
- Single frame: write 0x55 to addr 0 -> tx_out over 40 cycles is, in 4-cycle groups, 0,1,0,1,0,1,0,1,0,1. char_sent is a single pulse at cycle 40. Status goes 0x1 during the frame and 0x2 after.
- LSB ordering and readback: write 0xA3 -> data bits on the line are 1,1,0,0,0,1,0,1. A read of addr 0 returns 0x000000A3 one cycle after the address.
- Overrun: write 0x11, then write 0x22 at cycle 10 -> the line still carries 0x11; addr 0 reads 0x11; status after completion is 0x6.
- Clear collision: issue the addr-1 write in the cycle char_sent is high -> status reads 0x2 afterward. An addr-1 write one cycle later -> status 0x0.
- Unused addresses: reads of addr 2 and 3 return 0. Writes to addr 2 and 3, and writes with chipselect = 0, start no frame and leave status at 0x0.
